fetch_prefix_queue: RTL

Byte-granular fetch queue and prefix pre-decoder that sits between instruction fetch and the opcode/operand decoder. It accepts fixed-width fetch chunks into a circular byte buffer and presents a 15-byte window aligned to the current instruction start. With the window it presents the pre-parsed legacy-prefix, REX and error fields. It retires a variable number of bytes per handshake, as reported back by the decoder. Compared with the single-instruction decode function, it adds configurable chunk/buffer/prefix-limit parameters, a 32/64-bit mode, prefix-overflow detection, buffering across chunk boundaries, and redirect flush.

---
 rtl/fetch_prefix_queue.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_prefix_queue.sv
// Byte-granular fetch queue with a 15-byte decode window aligned to the instruction start,
// plus a combinational legacy-prefix / REX pre-decoder over the head of the queue.
module fetch_prefix_queue #(
  parameter int          FETCH_BYTES       = 16,
  parameter int          BUF_BYTES         = 64,
  parameter int          MAX_LEGACY_PREFIX = 4,
  parameter logic [63:0] RESET_PC          = 64'h0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic [FETCH_BYTES*8-1:0] fetch_bytes,
  input  logic                     mode64,
  input  logic                     flush,
  input  logic [63:0]              flush_pc,
  output logic                     dc_valid,
  input  logic                     dc_ready,
  input  logic [3:0]               dc_len,
  output logic [119:0]             dc_window,
  output logic [63:0]              dc_pc,
  output logic [7:0]               dc_lock_repeat,
  output logic [7:0]               dc_segment,
  output logic [7:0]               dc_opsize,
  output logic [7:0]               dc_addrsize,
  output logic [7:0]               dc_rex,
  output logic [3:0]               dc_prefix_cnt,
  output logic [3:0]               dc_opcode_offset,
  output logic                     dc_error
);

  localparam int PTR_W = $clog2(BUF_BYTES);
  localparam int WIN   = 15;
  localparam logic [PTR_W:0] FILL_LIMIT = (PTR_W+1)'(BUF_BYTES - FETCH_BYTES);
  localparam logic [PTR_W:0] WIN_CNT    = (PTR_W+1)'(WIN);

  localparam logic [2:0] GRP_NONE = 3'd0;
  localparam logic [2:0] GRP_LOCK = 3'd1;
  localparam logic [2:0] GRP_SEG  = 3'd2;
  localparam logic [2:0] GRP_OPSZ = 3'd3;
  localparam logic [2:0] GRP_ADSZ = 3'd4;

  function automatic logic [2:0] prefix_group(input logic [7:0] b);
    case (b)
      8'hF0, 8'hF2, 8'hF3:                         prefix_group = GRP_LOCK;
      8'h2E, 8'h3E, 8'h26, 8'h64, 8'h65, 8'h36:    prefix_group = GRP_SEG;
      8'h66:                                       prefix_group = GRP_OPSZ;
      8'h67:                                       prefix_group = GRP_ADSZ;
      default:                                     prefix_group = GRP_NONE;
    endcase
  endfunction

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;
  logic [63:0]      pc;
  logic [7:0]       mem [BUF_BYTES];
  logic [7:0]       win [WIN];

  logic             fetch_fire, cons_fire;
  logic [3:0]       cons_len;
  logic [PTR_W:0]   fetch_add, cons_sub;

  assign fetch_ready = !flush && (count <= FILL_LIMIT);
  assign dc_valid    = !flush && (count >= WIN_CNT);
  assign fetch_fire  = fetch_valid && fetch_ready;
  assign cons_fire   = dc_valid && dc_ready;
  // A zero length would stall the stream forever, so it retires one byte.
  assign cons_len    = (dc_len == 4'd0) ? 4'd1 : dc_len;
  assign fetch_add   = fetch_fire ? (PTR_W+1)'(FETCH_BYTES) : '0;
  assign cons_sub    = cons_fire ? (PTR_W+1)'(cons_len) : '0;
  assign dc_pc       = pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pc     <= RESET_PC;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pc     <= flush_pc;
    end else begin
      if (fetch_fire) wr_ptr <= wr_ptr + PTR_W'(FETCH_BYTES);
      if (cons_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(cons_len);
        pc     <= pc + 64'(cons_len);
      end
      count <= count + fetch_add - cons_sub;
    end
  end

  // Byte storage carries no reset; pointer arithmetic wraps naturally at BUF_BYTES.
  always_ff @(posedge clk) begin
    if (fetch_fire) begin
      for (int j = 0; j < FETCH_BYTES; j++)
        mem[wr_ptr + PTR_W'(j)] <= fetch_bytes[(FETCH_BYTES-1-j)*8 +: 8];
    end
  end

  for (genvar g = 0; g < WIN; g++) begin : g_win
    assign win[g] = mem[rd_ptr + PTR_W'(g)];
    assign dc_window[(WIN-1-g)*8 +: 8] = win[g];
  end

  logic [7:0] lock_s, seg_s, opsz_s, adsz_s, rex_s, next_s;
  logic [3:0] cnt_s;
  logic       scanning, err_s;

  always_comb begin
    lock_s   = '0;
    seg_s    = '0;
    opsz_s   = '0;
    adsz_s   = '0;
    cnt_s    = '0;
    scanning = 1'b1;
    for (int i = 0; i < MAX_LEGACY_PREFIX; i++) begin
      if (scanning) begin
        case (prefix_group(win[i]))
          GRP_LOCK: lock_s = win[i];
          GRP_SEG:  seg_s  = win[i];
          GRP_OPSZ: opsz_s = win[i];
          GRP_ADSZ: adsz_s = win[i];
          default:  scanning = 1'b0;
        endcase
        if (scanning) cnt_s = cnt_s + 4'd1;
      end
    end
    next_s = win[cnt_s];
    err_s  = (cnt_s == 4'(MAX_LEGACY_PREFIX)) && (prefix_group(next_s) != GRP_NONE);
    rex_s  = (mode64 && next_s[7:4] == 4'h4) ? next_s : 8'h00;
  end

  // Decode fields are only meaningful over a full window; hold them at zero otherwise.
  always_comb begin
    dc_lock_repeat   = dc_valid ? lock_s : 8'h00;
    dc_segment       = dc_valid ? seg_s  : 8'h00;
    dc_opsize        = dc_valid ? opsz_s : 8'h00;
    dc_addrsize      = dc_valid ? adsz_s : 8'h00;
    dc_rex           = dc_valid ? rex_s  : 8'h00;
    dc_prefix_cnt    = dc_valid ? cnt_s  : 4'd0;
    dc_opcode_offset = dc_valid ? (cnt_s + {3'b000, rex_s != 8'h00}) : 4'd0;
    dc_error         = dc_valid && err_s;
  end

endmodule
